// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with flush/hold/bubble control
// and saturating bubble/flush performance counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned PC_W = 32,
  parameter logic [PC_W-1:0] PC_RST = 32'h00003000,
  parameter int unsigned EXC_W = 5,
  parameter bit BUBBLE_KEEP_PC = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              clr_cnt,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc_now,
  input  logic [EXC_W-1:0]  in_exc_pre,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [EXC_W-1:0] exc_merged;
  logic             bubble_fire;
  logic             kill_fire;

  // An invalid slot never raises an exception; the newest cause wins.
  always_comb begin
    exc_merged = '0;
    if (in_valid) begin
      exc_merged = (in_exc_now != '0) ? in_exc_now : in_exc_pre;
    end
  end

  assign bubble_fire = bubble && !flush && !hold;
  assign kill_fire = flush && out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pc    <= PC_RST;
      out_data  <= '0;
      out_bd    <= 1'b0;
      out_exc   <= '0;
    end else begin
      priority case (1'b1)
        flush: begin
          out_valid <= 1'b0;
          out_pc    <= PC_RST;
          out_data  <= '0;
          out_bd    <= 1'b0;
          out_exc   <= '0;
        end
        hold: begin
          out_valid <= out_valid;
        end
        bubble: begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_exc   <= '0;
          out_pc    <= BUBBLE_KEEP_PC ? in_pc : PC_RST;
          out_bd    <= BUBBLE_KEEP_PC ? in_bd : 1'b0;
        end
        default: begin
          out_valid <= in_valid;
          out_pc    <= in_pc;
          out_data  <= in_data;
          out_bd    <= in_bd;
          out_exc   <= exc_merged;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubble_fire && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
      if (kill_fire && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (default, no-PC bubble,
// 4-bit counters) checked every cycle against a behavioural model.
module tb_pipe_stage_reg;

  logic         clk;
  logic         reset;
  logic         flush, hold, bubble, clr_cnt;
  logic         in_valid, in_bd;
  logic [31:0]  in_pc;
  logic [127:0] in_data;
  logic [4:0]   in_exc_now, in_exc_pre;

  logic         a_valid, b_valid, c_valid;
  logic [31:0]  a_pc, b_pc, c_pc;
  logic [127:0] a_data, b_data, c_data;
  logic         a_bd, b_bd, c_bd;
  logic [4:0]   a_exc, b_exc, c_exc;
  logic [15:0]  a_bcnt, a_fcnt, b_bcnt, b_fcnt;
  logic [3:0]   c_bcnt, c_fcnt;

  int checks = 0;
  int failures = 0;

  pipe_stage_reg u_a (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .bubble(bubble), .clr_cnt(clr_cnt), .in_valid(in_valid),
    .in_pc(in_pc), .in_data(in_data), .in_bd(in_bd),
    .in_exc_now(in_exc_now), .in_exc_pre(in_exc_pre),
    .out_valid(a_valid), .out_pc(a_pc), .out_data(a_data),
    .out_bd(a_bd), .out_exc(a_exc),
    .bubble_cnt(a_bcnt), .flush_cnt(a_fcnt)
  );

  pipe_stage_reg #(.BUBBLE_KEEP_PC(1'b0)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .bubble(bubble), .clr_cnt(clr_cnt), .in_valid(in_valid),
    .in_pc(in_pc), .in_data(in_data), .in_bd(in_bd),
    .in_exc_now(in_exc_now), .in_exc_pre(in_exc_pre),
    .out_valid(b_valid), .out_pc(b_pc), .out_data(b_data),
    .out_bd(b_bd), .out_exc(b_exc),
    .bubble_cnt(b_bcnt), .flush_cnt(b_fcnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .bubble(bubble), .clr_cnt(clr_cnt), .in_valid(in_valid),
    .in_pc(in_pc), .in_data(in_data), .in_bd(in_bd),
    .in_exc_now(in_exc_now), .in_exc_pre(in_exc_pre),
    .out_valid(c_valid), .out_pc(c_pc), .out_data(c_data),
    .out_bd(c_bd), .out_exc(c_exc),
    .bubble_cnt(c_bcnt), .flush_cnt(c_fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state per instance: 0=default, 1=no-PC bubble, 2=4-bit counters.
  logic         m_valid [3];
  logic [31:0]  m_pc [3];
  logic [127:0] m_data [3];
  logic         m_bd [3];
  logic [4:0]   m_exc [3];
  int           m_bcnt [3];
  int           m_fcnt [3];
  int           cmax [3] = '{65535, 65535, 15};
  bit           keep [3] = '{1'b1, 1'b0, 1'b1};

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        m_valid[i] = 1'b0; m_pc[i] = 32'h3000; m_data[i] = '0;
        m_bd[i] = 1'b0; m_exc[i] = '0; m_bcnt[i] = 0; m_fcnt[i] = 0;
      end else begin
        if (clr_cnt) begin
          m_bcnt[i] = 0;
          m_fcnt[i] = 0;
        end else begin
          if (flush && m_valid[i]) m_fcnt[i] = (m_fcnt[i] == cmax[i]) ? cmax[i] : m_fcnt[i] + 1;
          if (!flush && !hold && bubble) m_bcnt[i] = (m_bcnt[i] == cmax[i]) ? cmax[i] : m_bcnt[i] + 1;
        end
        if (flush) begin
          m_valid[i] = 1'b0; m_pc[i] = 32'h3000; m_data[i] = '0;
          m_bd[i] = 1'b0; m_exc[i] = '0;
        end else if (!hold && bubble) begin
          m_valid[i] = 1'b0; m_data[i] = '0; m_exc[i] = '0;
          m_pc[i] = keep[i] ? in_pc : 32'h3000;
          m_bd[i] = keep[i] ? in_bd : 1'b0;
        end else if (!hold) begin
          m_valid[i] = in_valid; m_pc[i] = in_pc;
          m_data[i] = in_data; m_bd[i] = in_bd;
          if (!in_valid) m_exc[i] = '0;
          else if (in_exc_now != 0) m_exc[i] = in_exc_now;
          else m_exc[i] = in_exc_pre;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_valid", a_valid, m_valid[0]); chk("a_pc", a_pc, m_pc[0]);
    chk("a_data", a_data, m_data[0]); chk("a_bd", a_bd, m_bd[0]);
    chk("a_exc", a_exc, m_exc[0]);
    chk("a_bcnt", a_bcnt, m_bcnt[0]); chk("a_fcnt", a_fcnt, m_fcnt[0]);
    chk("b_valid", b_valid, m_valid[1]); chk("b_pc", b_pc, m_pc[1]);
    chk("b_data", b_data, m_data[1]); chk("b_bd", b_bd, m_bd[1]);
    chk("b_exc", b_exc, m_exc[1]);
    chk("b_bcnt", b_bcnt, m_bcnt[1]); chk("b_fcnt", b_fcnt, m_fcnt[1]);
    chk("c_valid", c_valid, m_valid[2]); chk("c_pc", c_pc, m_pc[2]);
    chk("c_data", c_data, m_data[2]); chk("c_exc", c_exc, m_exc[2]);
    chk("c_bcnt", c_bcnt, m_bcnt[2]); chk("c_fcnt", c_fcnt, m_fcnt[2]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic f, input logic h, input logic b,
                     input logic c);
    flush = f; hold = h; bubble = b; clr_cnt = c;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic bd, input logic [4:0] now,
                       input logic [4:0] pre);
    in_valid = v; in_pc = pc; in_bd = bd;
    in_exc_now = now; in_exc_pre = pre;
    in_data = {4{pc ^ 32'hA5A5_0000}};
  endtask

  initial begin
    reset = 1'b0;
    ctl(0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    step(); step();
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_pc", a_pc, 32'h00003000);
    reset = 1'b1;
    step();

    drive(1, 32'h00003010, 0, 5'd0, 5'd4);
    step();
    chk("ld_exc_pre", a_exc, 5'd4);
    chk("ld_pc", a_pc, 32'h00003010);
    drive(1, 32'h00003010, 0, 5'd10, 5'd4);
    step();
    chk("ld_exc_now", a_exc, 5'd10);
    drive(0, 32'h00003014, 0, 5'd10, 5'd4);
    step();
    chk("inv_exc", a_exc, 5'd0);
    chk("inv_valid", a_valid, 1'b0);

    drive(1, 32'h00003020, 1, 0, 0);
    step();
    drive(1, 32'h00003024, 0, 5'd3, 0);
    ctl(0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_pc", a_pc, 32'h00003020);
      chk("hold_valid", a_valid, 1'b1);
      chk("hold_bcnt", a_bcnt, 16'd0);
    end
    ctl(0, 0, 1, 0);
    step();
    chk("bub_valid", a_valid, 1'b0);
    chk("bub_pc", a_pc, 32'h00003024);
    chk("bub_cnt", a_bcnt, 16'd1);

    ctl(0, 0, 0, 0);
    drive(1, 32'h00003030, 0, 0, 5'd2);
    step();
    ctl(1, 1, 0, 0);
    step();
    chk("fl_valid", a_valid, 1'b0);
    chk("fl_pc", a_pc, 32'h00003000);
    chk("fl_cnt", a_fcnt, 16'd1);
    step();
    chk("fl_cnt_idle", a_fcnt, 16'd1);

    ctl(0, 0, 1, 0);
    drive(1, 32'h00003044, 1, 0, 0);
    step();
    chk("nokeep_pc", b_pc, 32'h00003000);
    chk("nokeep_bd", b_bd, 1'b0);
    chk("keep_pc", a_pc, 32'h00003044);
    chk("keep_bd", a_bd, 1'b1);

    for (int k = 0; k < 20; k++) step();
    chk("sat_bcnt", c_bcnt, 4'hF);
    chk("wide_bcnt", a_bcnt, 16'd22);
    ctl(0, 0, 1, 1);
    step();
    chk("clr_bcnt", c_bcnt, 4'h0);
    chk("clr_fcnt", a_fcnt, 16'd0);
    chk("clr_pc", a_pc, 32'h00003044);

    ctl(0, 0, 0, 0);
    drive(1, 32'h00003050, 0, 0, 0);
    step(); step();
    ctl(0, 0, 1, 0);
    step();
    ctl(0, 0, 0, 0);
    step();
    chk("pre_rst_valid", a_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", a_valid, 1'b0);
    chk("async_pc", a_pc, 32'h00003000);
    chk("async_bcnt", a_bcnt, 16'd0);
    chk("async_fcnt", c_fcnt, 4'd0);
    step();
    reset = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the MIPS pipeline. Replaces the per-stage hand-written registers (D/E, E/M, M/W).
- Carries a valid bit, PC, packed payload, branch-delay flag and exception code.
- Separates three controls: flush, hold (freeze) and bubble (NOP insert).
- Keeps saturating bubble and flush counters for performance debug.

Parameters:
- DATA_W, 128, packed payload width (IR, operands, immediates, concatenated by the instantiating stage).
- PC_W, 32, PC field width.
- PC_RST, 32'h00003000, PC value loaded on reset and flush.
- EXC_W, 5, exception-code width; 0 means no exception.
- BUBBLE_KEEP_PC, 1, when 1 a bubble carries in_pc/in_bd; when 0 it loads PC_RST and bd=0.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- flush  in  1  interrupt/exception kill of this stage.
- hold  in  1  freeze: the stage keeps its contents.
- bubble  in  1  load a NOP instead of the input.
- clr_cnt  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream slot holds a real instruction.
- in_pc  in  PC_W  upstream PC.
- in_data  in  DATA_W  upstream payload.
- in_bd  in  1  upstream instruction is in a branch delay slot.
- in_exc_now  in  EXC_W  exception detected in the upstream stage.
- in_exc_pre  in  EXC_W  exception carried from earlier stages.
- out_valid  out  1  registered valid.
- out_pc  out  PC_W  registered PC.
- out_data  out  DATA_W  registered payload.
- out_bd  out  1  registered delay-slot flag.
- out_exc  out  EXC_W  registered merged exception code.
- bubble_cnt  out  CNT_W  count of bubble cycles applied.
- flush_cnt  out  CNT_W  count of valid instructions killed by flush.

Behaviour:
- Reset, asynchronous on reset==0:
  - out_valid=0, out_pc=PC_RST, out_data=0, out_bd=0, out_exc=0.
  - Both counters = 0.
  - Takes effect immediately and overrides everything, including mid-hold.
- Per rising edge, priority is flush > hold > bubble > load. Exactly one action applies.
- FLUSH:
  - out_valid=0, out_pc=PC_RST, out_data=0, out_bd=0, out_exc=0.
  - Flush wins over a simultaneous hold. Interrupts are never blocked by stalls.
- HOLD: all data outputs keep their value. Bubble is ignored while hold=1.
- BUBBLE:
  - out_valid=0, out_data=0, out_exc=0.
  - If BUBBLE_KEEP_PC=1: out_pc=in_pc, out_bd=in_bd. This keeps EPC computable from a bubble slot.
  - If BUBBLE_KEEP_PC=0: out_pc=PC_RST, out_bd=0.
- LOAD:
  - out_valid=in_valid, out_pc=in_pc, out_data=in_data, out_bd=in_bd.
  - out_exc = (in_exc_now!=0) ? in_exc_now : in_exc_pre, when in_valid=1.
  - out_exc = 0 when in_valid=0. An invalid slot never raises an exception.
- Latency: 1 cycle input to output in LOAD. No combinational path from any input to any output.
- Counters:
  - Both saturate at all-ones and never wrap.
  - bubble_cnt increments only on edges where the BUBBLE action is applied, not when masked by flush or hold.
  - flush_cnt increments on flush edges where out_valid==1 before the edge.
  - clr_cnt=1 zeroes both counters on the edge. It wins over a same-cycle increment.
  - clr_cnt does not affect the pipeline data outputs.
- All data fields are updated together. A partial update is a bug.

Test Plan:
- Reset: drive reset=0 mid-cycle while out_valid=1 → out_valid=0, out_pc=32'h00003000, counters=0, without waiting for a clock edge.
- Load and exception merge:
  - in_valid=1, in_pc=32'h00003010, in_exc_now=0, in_exc_pre=5'd4 → next edge out_exc=4, out_pc=32'h00003010.
  - Same with in_exc_now=5'd10 → out_exc=10.
  - in_valid=0 with in_exc_now=5'd10 → out_exc=0.
- Hold vs bubble: load PC 32'h00003020, then 3 cycles of hold=1 and bubble=1 → outputs unchanged for 3 cycles, bubble_cnt stays 0. Release hold with bubble=1 → out_valid=0, out_pc=in_pc, bubble_cnt=1.
- Flush priority: out_valid=1, then assert flush=1 and hold=1 together → out_valid=0, out_pc=32'h00003000, flush_cnt=1. Flush again with out_valid=0 → flush_cnt stays 1.
- BUBBLE_KEEP_PC=0 instance: bubble with in_pc=32'h00003044, in_bd=1 → out_pc=32'h00003000, out_bd=0.
- Saturation and clear: CNT_W=4, 20 consecutive bubbles → bubble_cnt=4'hF. clr_cnt=1 together with bubble=1 → bubble_cnt=0.
